// File: rtl/decode_pkg.sv
// Shared decode constants: RV opcodes, one-hot type bit indices, immediate formats
// and the decoded-field bundle with its classification helpers.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int TYPE_W   = 9;
  localparam int T_R      = 0;
  localparam int T_I      = 1;
  localparam int T_LOAD   = 2;
  localparam int T_STORE  = 3;
  localparam int T_BRANCH = 4;
  localparam int T_JAL    = 5;
  localparam int T_JALR   = 6;
  localparam int T_AUIPC  = 7;
  localparam int T_LUI    = 8;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_NONE} imm_fmt_e;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic              illegal;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } dec_fields_t;

  // Opcodes outside the table (including instr[1:0] != 2'b11) are illegal.
  function automatic dec_fields_t decode_fields(input logic [31:0] instr);
    dec_fields_t f;
    f        = '0;
    f.rd     = instr[11:7];
    f.rs1    = instr[19:15];
    f.rs2    = instr[24:20];
    f.funct3 = instr[14:12];
    f.funct7 = instr[31:25];
    case (instr[6:0])
      OP_R:      f.typ[T_R]      = 1'b1;
      OP_IMM:    f.typ[T_I]      = 1'b1;
      OP_LOAD:   f.typ[T_LOAD]   = 1'b1;
      OP_STORE:  f.typ[T_STORE]  = 1'b1;
      OP_BRANCH: f.typ[T_BRANCH] = 1'b1;
      OP_JAL:    f.typ[T_JAL]    = 1'b1;
      OP_JALR:   f.typ[T_JALR]   = 1'b1;
      OP_AUIPC:  f.typ[T_AUIPC]  = 1'b1;
      OP_LUI:    f.typ[T_LUI]    = 1'b1;
      default:   f.illegal       = 1'b1;
    endcase
    return f;
  endfunction

  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_JAL:                   fmt = FMT_J;
      OP_AUIPC, OP_LUI:         fmt = FMT_U;
      default:                  fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode and decode->execute handshake bundles.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; the
// master keeps valid and payload stable until then and never waits on ready.
interface fetch_dec_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, instr, pc, input ready);
  modport slave  (input valid, instr, pc, output ready);
endinterface

interface dec_exe_if
  import decode_pkg::*;
#(parameter int XLEN = 32);
  logic              valid;
  logic              ready;
  logic [TYPE_W-1:0] typ;
  logic              illegal;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc;

  modport master (output valid, typ, illegal, rd, rs1, rs2, funct3, funct7, imm, pc,
                  input ready);
  modport slave  (input valid, typ, illegal, rd, rs1, rs2, funct3, funct7, imm, pc,
                  output ready);
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV immediate format and
// sign-extends from instr[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_x64
      assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_x32
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer (main + skid).
// Optional DECODE_ILLEGAL_CNT_EN adds a saturating illegal-instruction counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  fetch_dec_if.slave  in_if,
  dec_exe_if.master   out_if,
`ifdef DECODE_ILLEGAL_CNT_EN
  input  logic        illegal_cnt_clr,
  output logic [15:0] illegal_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  dec_fields_t     main_f_q, main_f_d, skid_f_q, skid_f_d, new_f;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d, new_imm;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  imm_fmt_e        new_fmt;
  logic            accept, drain, out_valid;

  assign new_f   = decode_fields(in_if.instr);
  assign new_fmt = imm_format(in_if.instr[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_if.instr),
    .fmt   (new_fmt),
    .imm   (new_imm)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_if.valid & in_ready_q & ~flush;
  assign drain     = out_valid & out_if.ready;

  always_comb begin
    state_d    = state_q;
    main_f_d   = main_f_q;
    main_imm_d = main_imm_q;
    main_pc_d  = main_pc_q;
    skid_f_d   = skid_f_q;
    skid_imm_d = skid_imm_q;
    skid_pc_d  = skid_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_f_d = new_f; main_imm_d = new_imm; main_pc_d = in_if.pc;
          state_d  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && drain) begin
          main_f_d = new_f; main_imm_d = new_imm; main_pc_d = in_if.pc;
        end else if (accept) begin
          skid_f_d = new_f; skid_imm_d = new_imm; skid_pc_d = in_if.pc;
          state_d  = ST_SKID;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain can move anything.
        if (drain) begin
          main_f_d = skid_f_q; main_imm_d = skid_imm_q; main_pc_d = skid_pc_q;
          state_d  = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_f_q   <= '0;
      main_imm_q <= '0;
      main_pc_q  <= RESET_PC;
      skid_f_q   <= '0;
      skid_imm_q <= '0;
      skid_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_f_q   <= main_f_d;
      main_imm_q <= main_imm_d;
      main_pc_q  <= main_pc_d;
      skid_f_q   <= skid_f_d;
      skid_imm_q <= skid_imm_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  // Outputs read as zero / RESET_PC whenever no bundle is held.
  assign in_if.ready    = in_ready_q;
  assign out_if.valid   = out_valid;
  assign out_if.typ     = out_valid ? main_f_q.typ     : '0;
  assign out_if.illegal = out_valid ? main_f_q.illegal : 1'b0;
  assign out_if.rd      = out_valid ? main_f_q.rd      : '0;
  assign out_if.rs1     = out_valid ? main_f_q.rs1     : '0;
  assign out_if.rs2     = out_valid ? main_f_q.rs2     : '0;
  assign out_if.funct3  = out_valid ? main_f_q.funct3  : '0;
  assign out_if.funct7  = out_valid ? main_f_q.funct7  : '0;
  assign out_if.imm     = out_valid ? main_imm_q       : '0;
  assign out_if.pc      = out_valid ? main_pc_q        : RESET_PC;
  assign dbg_state      = state_q;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (illegal_cnt_clr) begin
      illegal_cnt_d = '0;
    end else if (drain && !flush && main_f_q.illegal && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_cnt_q <= '0;
    else        illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a field-level reference model feeds an
// expected queue, and a negedge monitor checks every output handshake.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RST_PC = 32'h0000_0100;
  localparam int W = 9 + 1 + 5 + 5 + 5 + 3 + 7 + XLEN + XLEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  fetch_dec_if #(.XLEN(XLEN)) in_if ();
  dec_exe_if   #(.XLEN(XLEN)) out_if ();

`ifdef DECODE_ILLEGAL_CNT_EN
  logic        illegal_cnt_clr = 1'b0;
  logic [15:0] illegal_cnt;
`endif

  decode_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
`ifdef DECODE_ILLEGAL_CNT_EN
    .illegal_cnt_clr (illegal_cnt_clr),
    .illegal_cnt     (illegal_cnt),
`endif
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ill = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_out;
  logic         prev_stall = 1'b0;
  logic         rnd_on = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // Reference: field extraction and immediates built arithmetically from the ISA rules.
  function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    logic [8:0] t;
    logic       ill;
    longint     s, imm;
    s = longint'($signed(ins));
    t = '0; ill = 1'b0; imm = 0;
    case (ins[6:0])
      7'h33: t = 9'h001;
      7'h13: begin t = 9'h002; imm = s >>> 20; end
      7'h03: begin t = 9'h004; imm = s >>> 20; end
      7'h23: begin t = 9'h008; imm = (s >>> 25) * 32 + longint'(ins[11:7]); end
      7'h63: begin
        t = 9'h010;
        imm = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h6F: begin
        t = 9'h020;
        imm = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      7'h67: begin t = 9'h040; imm = s >>> 20; end
      7'h17: begin t = 9'h080; imm = (s >>> 12) * 4096; end
      7'h37: begin t = 9'h100; imm = (s >>> 12) * 4096; end
      default: ill = 1'b1;
    endcase
    return {t, ill, ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[31:25], imm[XLEN-1:0], pc};
  endfunction

  function automatic logic [W-1:0] bundle();
    return {out_if.typ, out_if.illegal, out_if.rd, out_if.rs1, out_if.rs2,
            out_if.funct3, out_if.funct7, out_if.imm, out_if.pc};
  endfunction

  // Monitor: one pop per output handshake, plus one-hot and stall-stability checks.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      prev_stall = 1'b0;
    end else begin
      if (out_if.valid) begin
        check("onehot", W'($countones(out_if.typ)) + W'(out_if.illegal), W'(1));
        if (prev_stall) check("stable", bundle(), prev_out);
        if (out_if.ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_out");
          else begin
            if (out_if.illegal) exp_ill++;
            check("data", bundle(), exp_q.pop_front());
          end
        end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_out   = bundle();
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_if.ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bit done;
    bit acc;
    done = 1'b0;
    in_if.valid = 1'b1; in_if.instr = ins; in_if.pc = pc;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      acc = in_if.ready && !flush && rst_n;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(model(ins, pc));
        done = 1'b1;
      end
      #1;
    end
    in_if.valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic expect_out(input string nm, input logic [8:0] t, input logic ill,
                            input logic [4:0] rd, input logic [XLEN-1:0] imm);
    @(negedge clk);
    check({nm, "_valid"}, W'(out_if.valid), W'(1));
    check({nm, "_type"}, W'(out_if.typ), W'(t));
    check({nm, "_illegal"}, W'(out_if.illegal), W'(ill));
    check({nm, "_rd"}, W'(out_if.rd), W'(rd));
    check({nm, "_imm"}, W'(out_if.imm), W'(imm));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 200 && (exp_q.size() != 0); c++) cyc(1);
    cyc(1);
    check(nm, W'(exp_q.size()), W'(0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[11];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F, 7'h00};
    ins = $urandom();
    if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom());
    else ins[6:0] = ops[$urandom_range(0, 10)];
    return ins;
  endfunction

  initial begin
    #2_000_000;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_if.valid = 1'b0; in_if.instr = '0; in_if.pc = '0;
    out_if.ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", W'(out_if.valid), W'(0));
    check("rst_in_ready", W'(in_if.ready), W'(0));
    check("rst_type", W'(out_if.typ), W'(0));
    check("rst_imm", W'(out_if.imm), W'(0));
    check("rst_pc", W'(out_if.pc), W'(RST_PC));
    #10 rst_n = 1'b1;
    #2;
    check("rel_in_ready_low", W'(in_if.ready), W'(0));
    @(posedge clk); #1;
    check("rel_in_ready_high", W'(in_if.ready), W'(1));

    // Directed decodes
    out_if.ready = 1'b1;
    send(32'h0050_0093, 32'h0000_1000);
    expect_out("addi", 9'h002, 1'b0, 5'd1, 32'd5);
    send(32'h1234_5137, 32'h0000_1004);
    expect_out("lui", 9'h100, 1'b0, 5'd2, 32'h1234_5000);
    send(32'hFE00_0EE3, 32'h0000_1008);
    expect_out("beq", 9'h010, 1'b0, 5'd29, 32'hFFFF_FFFC);

    // Illegal encodings
`ifdef DECODE_ILLEGAL_CNT_EN
    illegal_cnt_clr = 1'b1; cyc(1); illegal_cnt_clr = 1'b0; exp_ill = 0;
`endif
    send(32'h0000_007F, 32'h0000_100C);
    expect_out("ill7f", 9'h000, 1'b1, 5'd0, 32'd0);
    send(32'h0000_0000, 32'h0000_1010);
    expect_out("ill00", 9'h000, 1'b1, 5'd0, 32'd0);
    cyc(1);
`ifdef DECODE_ILLEGAL_CNT_EN
    check("illegal_cnt2", W'(illegal_cnt), W'(2));
`endif

    // Backpressure: two accepted, third held until drain
    out_if.ready = 1'b0;
    send(32'h0020_8133, 32'h0000_2000);
    send(32'h0041_2183, 32'h0000_2004);
    fork
      send(32'h0031_2223, 32'h0000_2008);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", W'(in_if.ready), W'(0));
          check("bp_valid", W'(out_if.valid), W'(1));
        end
        @(posedge clk); #1;
        out_if.ready = 1'b1;
      end
    join
    wait_drain("bp_drain");

    // Flush in SKID state; a coincident input is dropped too
    out_if.ready = 1'b0;
    send(32'h0010_0093, 32'h0000_3000);
    send(32'h0020_0113, 32'h0000_3004);
    in_if.valid = 1'b1; in_if.instr = 32'h0030_0193; in_if.pc = 32'h0000_3008;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_if.valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", W'(out_if.valid), W'(0));
    check("flush_in_ready", W'(in_if.ready), W'(1));
    @(posedge clk); #1;
    out_if.ready = 1'b1;
    cyc(5);
    check("flush_empty", W'(out_if.valid), W'(0));

    // Async reset mid-stream
    out_if.ready = 1'b0;
    send(32'h0010_0093, 32'h0000_4000);
    send(32'h0020_0113, 32'h0000_4004);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", W'(out_if.valid), W'(0));
    check("arst_in_ready", W'(in_if.ready), W'(0));
    exp_q.delete();
    exp_ill = 0;
    cyc(2);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_if.ready = 1'b1;
    send(32'h0050_0093, 32'h0000_5000);
    expect_out("post_rst", 9'h002, 1'b0, 5'd1, 32'd5);

    // Randomized traffic with random backpressure
    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 2));
      send(rand_instr(), XLEN'($urandom()));
    end
    rnd_on = 1'b0;
    cyc(1);
    out_if.ready = 1'b1;
    wait_drain("rand_drain");
`ifdef DECODE_ILLEGAL_CNT_EN
    check("illegal_cnt_total", W'(illegal_cnt), W'(exp_ill));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage between fetch and execute in the single-cycle-to-pipelined core.
- Classifies each opcode into a one-hot type vector (r_type, i_type, load, store, branch, jal, jalr, auipc, lui).
- Extracts register indices and function fields, and generates the sign-extended immediate.
- Flags illegal encodings; valid/ready handshake on both sides with a 2-entry skid buffer.

Parameters:
- XLEN, 32, datapath width for pc and immediate; legal values 32 or 64.
- RESET_PC, 0, value driven on out_pc while empty/after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush; drops all held entries
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept; registered, equals !skid_full
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_type  output  9  one-hot {lui,auipc,jalr,jal,branch,store,load,i_type,r_type}; bit0=r_type
- out_illegal  output  1  unrecognised opcode or instr[1:0]!=2'b11
- out_rd, out_rs1, out_rs2  output  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_imm  output  XLEN  sign-extended immediate per format
- out_pc  output  XLEN  pc of decoded instruction

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=0, all data outputs 0, out_pc=RESET_PC; in_ready goes 1 on first clk edge after deassert.
- Latency: 1 cycle; instruction accepted on edge N (in_valid&in_ready) appears with out_valid=1 after edge N.
- Handshake: transfer only when valid&ready; out_* stable while out_valid&!out_ready; in_valid must not depend on in_ready.
- FSM (states):
  - EMPTY: accept → FULL.
  - FULL: accept&&drain → FULL; accept&&!drain → SKID (in_ready drops next cycle); !accept&&drain → EMPTY.
  - SKID: main+skid held; drain → FULL, skid moves to main, in_ready=1.
- Classification:
  - Opcodes 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0010111 auipc, 0110111 lui.
  - Anything else: out_type=0, out_illegal=1; exactly one type bit or illegal asserted per valid bundle.
- Immediate formats, sign bit instr[31], sign-extended to XLEN:
  - I (i_type/load/jalr): instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - U: {instr[31:12],12'b0}.
  - R and illegal: imm=0.
- Flush: highest priority; next cycle state=EMPTY, out_valid=0, in_ready=1; a handshake coinciding with flush is discarded.
- Reset mid-operation discards all entries, no partial outputs.

Optional Feature:
- Macro: DECODE_ILLEGAL_CNT_EN.
- Defined:
  - Adds output port illegal_cnt [15:0] and input illegal_cnt_clr.
  - Counter increments on each output handshake with out_illegal=1; saturates at 0xFFFF.
  - Cleared by reset or illegal_cnt_clr; clr wins over a same-cycle increment.
- Undefined: ports and counter absent; behaviour otherwise identical.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI).
  - type-bit index constants (T_R..T_LUI), TYPE_W=9, imm-format enum {FMT_I,FMT_S,FMT_B,FMT_J,FMT_U,FMT_NONE}.
- Sub-module imm_gen (combinational, parameter XLEN): instr+format → out_imm; used before the pipeline register.

Test Plan:
- 0x00500093 (addi x1,x0,5) → one cycle later out_type=9'h002, rd=1, rs1=0, imm=5, illegal=0.
- 0x12345137 (lui x2,0x12345) → out_type=9'h100, rd=2, imm=0x12345000 (XLEN=64: 0x0000000012345000); 0xFE000EE3 (beq -4) → type=9'h010, imm=0xFFFFFFFC.
- out_ready=0, three back-to-back in_valid pulses → first two accepted, in_ready=0 after the second, third held; raise out_ready → in-order drain, no loss or duplication.
- 0x0000007F and 0x00000000 → out_illegal=1, out_type=0, imm=0; with DECODE_ILLEGAL_CNT_EN, illegal_cnt=2.
- Stage in SKID state, assert flush → next cycle out_valid=0, in_ready=1; queued instructions never appear.
- Assert rst_n low asynchronously mid-stream → out_valid drops immediately without waiting for clk; after release, first new instruction decodes correctly.
